cmi_rx_packet_buffer: RTL
=========================

Name: cmi_rx_packet_buffer

Overview:
- Consumer stage directly downstream of the CMI receive path in the single-packet manager.
- Takes the decoded packet bus (header, four data words, ready strobe, fault strobe) and stores packets in a small FIFO that the application reads at its own pace.
- Checks sequence-number continuity (header bits [7:2]) and monitors link liveness with a timeout.
- Keeps saturating statistics for lost, faulty and dropped packets.

Parameters:
- DEPTH_LOG2, 2, FIFO depth is 2**DEPTH_LOG2 packets.
- TIMEOUT_CLKS, 50000, clocks without a valid packet before the link is declared lost (1 ms at 50 MHz).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- cmi_head_in  in  8  received header; [7:2]=seq, [1:0]=type
- cmi_data0_in..cmi_data3_in  in  16 each  received data words
- cmi_in_st  in  1  one-clock strobe: packet valid on the bus
- cmi_fault  in  1  one-clock strobe: corrupted packet
- rd_ack  in  1  consumer pops the head entry
- clr_stat  in  1  clear counters and sticky flags
- rd_valid  out  1  FIFO not empty
- rd_head  out  8  head-entry header
- rd_data0..rd_data3  out  16 each  head-entry data
- link_ok  out  1  link alive and sequence-synchronised
- seq_err  out  1  one-clock pulse on a sequence discontinuity
- ovf_flag  out  1  sticky: a packet was dropped because the FIFO was full
- lost_cnt  out  CNT_W  packets missed according to the sequence numbers
- fault_cnt  out  CNT_W  fault strobes received
- drop_cnt  out  CNT_W  packets dropped on overflow

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs, counters and FIFO pointers go to 0. link_ok=0, synced=0, timeout counter=0.
- Accept: cmi_in_st=1 and cmi_fault=0 in cycle N means the 72-bit word {head,d0,d1,d2,d3} is captured at edge N.
- Fault: cmi_fault=1 (including when cmi_in_st=1 in the same cycle) discards the packet and increments fault_cnt. The timeout counter and sequence state are untouched.
- FIFO:
  - Show-ahead. A write into an empty FIFO at edge N gives rd_valid=1 with data valid in cycle N+1.
  - rd_ack pops only when rd_valid=1; rd_ack with rd_valid=0 is ignored.
  - Full FIFO with an accepted packet and rd_ack=1 in the same cycle: pop and push both happen, no drop.
  - Full FIFO with an accepted packet and rd_ack=0: drop the packet, drop_cnt+1, ovf_flag<=1.
  - Pointers wrap modulo depth; full/empty are tracked with an extra pointer bit.
- Sequence check (accepted packets only):
  - exp_seq = last_seq+1 mod 64 and delta = (seq - exp_seq) mod 64.
  - If synced=1 and delta!=0: seq_err pulses at N+1 and lost_cnt += delta, saturating.
  - Every accepted packet sets last_seq<=seq, synced<=1, link_ok<=1.
  - The first packet after reset or after a timeout is not checked.
  - Dropped packets still update the sequence state.
- Timeout:
  - The counter clears on every accepted packet and otherwise increments.
  - On reaching TIMEOUT_CLKS-1: link_ok<=0, synced<=0, and the counter holds.
  - FIFO contents are preserved on timeout.
- Counters: all saturate at 2**CNT_W-1.
- clr_stat: zeroes lost_cnt, fault_cnt, drop_cnt and ovf_flag. When it coincides with an increment, the clear wins. FIFO and link state are unaffected.
- Reset asserted mid-operation flushes the FIFO immediately, because rst is asynchronous.

Decomposition:
- Shared include cmi_defs.vh holds:
  - CMI_SEQ_W=6
  - CMI_SEQ_MSB=7, CMI_SEQ_LSB=2
  - CMI_TYPE field [1:0]
  - CMI_PKT_W=72
- Sub-module cmi_pkt_fifo: a synchronous show-ahead FIFO with parameters WIDTH and DEPTH_LOG2, ports wr_en/rd_en/full/empty/dout, and async active-high rst.
- The top level holds the sequence checker, timeout logic and counters.

Test Plan:
- Reset, then packets with seq 0,1,2,3 (header 0x00,0x04,0x08,0x0C) and rd_ack idle -> rd_valid=1 one cycle after the first strobe; 4 entries in order; seq_err never pulses; link_ok=1 after the first packet.
- seq 5 then seq 9 -> seq_err pulses once; lost_cnt=3.
- Wrap: seq 63 then seq 0 -> no seq_err. seq 62 then seq 1 -> lost_cnt+=2.
- 5 packets into a depth-4 FIFO with no rd_ack -> drop_cnt=1, ovf_flag=1, and entries 1-4 are retained. A 6th packet on a full FIFO with rd_ack=1 in the same cycle -> no drop and the FIFO stays full.
- cmi_fault alone, then cmi_fault together with cmi_in_st -> fault_cnt=2, nothing written, sequence state unchanged. Then clr_stat together with a fault -> fault_cnt=0.
- Packet, then silence for TIMEOUT_CLKS clocks -> link_ok=0 at the expected cycle. Next packet with seq 40 -> link_ok=1, no seq_err, lost_cnt unchanged.

Source files
------------

// File: rtl/cmi_rx_packet_buffer_pkg.sv
// Shared CMI packet field definitions and helpers for the receive packet buffer.
// The header carries a 6-bit sequence number in [7:2] and the packet type in [1:0].
package cmi_rx_packet_buffer_pkg;

    localparam int CMI_SEQ_W    = 6;
    localparam int CMI_SEQ_MSB  = 7;
    localparam int CMI_SEQ_LSB  = 2;
    localparam int CMI_TYPE_MSB = 1;
    localparam int CMI_TYPE_LSB = 0;
    localparam int CMI_PKT_W    = 72;

    typedef logic [CMI_SEQ_W-1:0] cmi_seq_t;

    typedef struct packed {
        logic [7:0]  head;
        logic [15:0] data0;
        logic [15:0] data1;
        logic [15:0] data2;
        logic [15:0] data3;
    } cmi_pkt_t;

    // Number of packets skipped between last_seq and seq, modulo the sequence space.
    function automatic cmi_seq_t cmi_seq_gap(input cmi_seq_t seq, input cmi_seq_t last_seq);
        cmi_seq_t one;
        one = {{(CMI_SEQ_W-1){1'b0}}, 1'b1};
        return seq - last_seq - one;
    endfunction

endpackage

// File: rtl/cmi_rx_packet_buffer_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head entry while not empty.
// Full and empty are distinguished by one extra pointer bit.
module cmi_pkt_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DEPTH_LOG2:0] wr_ptr_r;
    logic [DEPTH_LOG2:0] rd_ptr_r;
    logic [WIDTH-1:0]    mem_r [DEPTH];
    logic                empty_s;
    logic                full_s;
    logic                do_wr_s;
    logic                do_rd_s;

    // Occupancy flags; a write into a full FIFO is allowed when the head leaves in the same cycle.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                  (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
        do_rd_s = rd_en & ~empty_s;
        do_wr_s = wr_en & (~full_s | do_rd_s);
    end

    // Read and write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(DEPTH_LOG2+1){1'b0}};
            rd_ptr_r <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage is cleared on reset so the head outputs read zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_wr_s) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= din;
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign dout  = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/cmi_rx_packet_buffer.sv
// CMI receive packet buffer: queues decoded packets for the application, checks
// sequence continuity, supervises link liveness and keeps saturating statistics.
module cmi_rx_packet_buffer
    import cmi_rx_packet_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2   = 2,
    parameter int TIMEOUT_CLKS = 50000,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       cmi_head_in,
    input  logic [15:0]      cmi_data0_in,
    input  logic [15:0]      cmi_data1_in,
    input  logic [15:0]      cmi_data2_in,
    input  logic [15:0]      cmi_data3_in,
    input  logic             cmi_in_st,
    input  logic             cmi_fault,
    input  logic             rd_ack,
    input  logic             clr_stat,
    output logic             rd_valid,
    output logic [7:0]       rd_head,
    output logic [15:0]      rd_data0,
    output logic [15:0]      rd_data1,
    output logic [15:0]      rd_data2,
    output logic [15:0]      rd_data3,
    output logic             link_ok,
    output logic             seq_err,
    output logic             ovf_flag,
    output logic [CNT_W-1:0] lost_cnt,
    output logic [CNT_W-1:0] fault_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int TO_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [TO_W-1:0]  TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             accept_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             seq_bad_s;
    cmi_seq_t         seq_s;
    cmi_seq_t         gap_s;
    cmi_pkt_t         in_pkt_s;
    cmi_pkt_t         fifo_dout_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W:0]   lost_sum_s;
    logic [CNT_W-1:0] lost_next_s;
    logic [CNT_W-1:0] fault_next_s;
    logic [CNT_W-1:0] drop_next_s;

    cmi_seq_t         last_seq_r;
    logic             synced_r;
    logic             link_ok_r;
    logic             seq_err_r;
    logic [TO_W-1:0]  to_cnt_r;
    logic [CNT_W-1:0] lost_cnt_r;
    logic [CNT_W-1:0] fault_cnt_r;
    logic [CNT_W-1:0] drop_cnt_r;
    logic             ovf_flag_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return CNT_MAX;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // Packet acceptance, FIFO flow control and sequence gap evaluation.
    always_comb begin
        accept_s  = cmi_in_st & ~cmi_fault;
        pop_s     = rd_ack & ~fifo_empty_s;
        push_s    = accept_s & (~fifo_full_s | pop_s);
        drop_s    = accept_s & fifo_full_s & ~pop_s;
        in_pkt_s  = '{head:  cmi_head_in,  data0: cmi_data0_in, data1: cmi_data1_in,
                      data2: cmi_data2_in, data3: cmi_data3_in};
        seq_s     = cmi_head_in[CMI_SEQ_MSB:CMI_SEQ_LSB];
        gap_s     = cmi_seq_gap(seq_s, last_seq_r);
        seq_bad_s = accept_s & synced_r & (gap_s != {CMI_SEQ_W{1'b0}});
    end

    // Saturating next values for the statistics counters.
    always_comb begin
        lost_sum_s   = {1'b0, lost_cnt_r} + {{(CNT_W+1-CMI_SEQ_W){1'b0}}, gap_s};
        fault_next_s = sat_inc(fault_cnt_r);
        drop_next_s  = sat_inc(drop_cnt_r);
        if (lost_sum_s[CNT_W]) begin
            lost_next_s = CNT_MAX;
        end else begin
            lost_next_s = lost_sum_s[CNT_W-1:0];
        end
    end

    cmi_pkt_fifo #(
        .WIDTH      (CMI_PKT_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (push_s),
        .din   (in_pkt_s),
        .rd_en (pop_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .dout  (fifo_dout_s)
    );

    // Sequence tracking and link supervision; dropped packets still advance the sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_seq_r <= {CMI_SEQ_W{1'b0}};
            synced_r   <= 1'b0;
            link_ok_r  <= 1'b0;
            seq_err_r  <= 1'b0;
            to_cnt_r   <= {TO_W{1'b0}};
        end else begin
            seq_err_r <= seq_bad_s;
            if (accept_s) begin
                last_seq_r <= seq_s;
                synced_r   <= 1'b1;
                link_ok_r  <= 1'b1;
                to_cnt_r   <= {TO_W{1'b0}};
            end else if (to_cnt_r == TO_LAST) begin
                synced_r  <= 1'b0;
                link_ok_r <= 1'b0;
            end else begin
                to_cnt_r <= to_cnt_r + TO_ONE;
            end
        end
    end

    // Statistics; a clear request overrides any increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost_cnt_r  <= {CNT_W{1'b0}};
            fault_cnt_r <= {CNT_W{1'b0}};
            drop_cnt_r  <= {CNT_W{1'b0}};
            ovf_flag_r  <= 1'b0;
        end else if (clr_stat) begin
            lost_cnt_r  <= {CNT_W{1'b0}};
            fault_cnt_r <= {CNT_W{1'b0}};
            drop_cnt_r  <= {CNT_W{1'b0}};
            ovf_flag_r  <= 1'b0;
        end else begin
            if (seq_bad_s) begin
                lost_cnt_r <= lost_next_s;
            end
            if (cmi_fault) begin
                fault_cnt_r <= fault_next_s;
            end
            if (drop_s) begin
                drop_cnt_r <= drop_next_s;
                ovf_flag_r <= 1'b1;
            end
        end
    end

    assign rd_valid  = ~fifo_empty_s;
    assign rd_head   = fifo_dout_s.head;
    assign rd_data0  = fifo_dout_s.data0;
    assign rd_data1  = fifo_dout_s.data1;
    assign rd_data2  = fifo_dout_s.data2;
    assign rd_data3  = fifo_dout_s.data3;
    assign link_ok   = link_ok_r;
    assign seq_err   = seq_err_r;
    assign ovf_flag  = ovf_flag_r;
    assign lost_cnt  = lost_cnt_r;
    assign fault_cnt = fault_cnt_r;
    assign drop_cnt  = drop_cnt_r;

endmodule
